// File: rtl/plru_replace_mp.sv
// Tree pseudo-LRU replacement unit: per-set binary tree, several hit-update ports,
// and a registered victim path that prefers invalid ways and skips locked ones.
module plru_replace_mp #(
    parameter int DEPTH      = 256,
    parameter int WAY_NUM    = 4,
    parameter int READ_PORT  = 2,
    parameter int WAY_WIDTH  = $clog2(WAY_NUM),
    parameter int ADDR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [READ_PORT-1:0]            hit_en,
    input  logic [READ_PORT*ADDR_WIDTH-1:0] hit_index,
    input  logic [READ_PORT*WAY_WIDTH-1:0]  hit_way,
    input  logic                            miss_req,
    input  logic [ADDR_WIDTH-1:0]           miss_index,
    input  logic [WAY_NUM-1:0]              miss_valid,
    input  logic [WAY_NUM-1:0]              miss_lock,
    output logic [WAY_WIDTH-1:0]            miss_way,
    output logic                            miss_way_valid,
    output logic                            miss_blocked
);

    localparam int NODE_NUM = WAY_NUM - 1;

    typedef logic [NODE_NUM-1:0]  tree_t;
    typedef logic [WAY_WIDTH-1:0] way_t;

    // Heap-ordered tree: children of node n are 2n+1 (left) and 2n+2 (right).
    // Every node on the path to w is pointed away from w.
    function automatic tree_t touch(input tree_t t, input way_t w);
        tree_t r;
        int    node;
        r    = t;
        node = 0;
        for (int lvl = WAY_WIDTH - 1; lvl >= 0; lvl--) begin
            r[node] = ~w[lvl];
            node    = 2 * node + (w[lvl] ? 2 : 1);
        end
        return r;
    endfunction

    function automatic way_t plru_victim(input tree_t t);
        way_t v;
        int   node;
        v    = '0;
        node = 0;
        for (int lvl = WAY_WIDTH - 1; lvl >= 0; lvl--) begin
            v[lvl] = t[node];
            node   = 2 * node + (t[node] ? 2 : 1);
        end
        return v;
    endfunction

    tree_t tree_q [DEPTH];
    tree_t tree_d [DEPTH];

    way_t  miss_way_q;
    logic  miss_way_valid_q;
    logic  miss_blocked_q;

    tree_t cur_tree;
    way_t  plru_way;
    way_t  sel_way;
    logic  sel_found;

    // Victim selection always works on the state registered at the start of the cycle.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        cur_tree  = '0;
        sel_found = 1'b0;
        sel_way   = '0;

        for (int s = 0; s < DEPTH; s++) begin
            if (miss_index == ADDR_WIDTH'(s)) begin
                cur_tree = tree_q[s];
            end
        end
        plru_way = plru_victim(cur_tree);

        for (int i = 0; i < WAY_NUM; i++) begin
            if (!sel_found && !miss_valid[i] && !miss_lock[i]) begin
                sel_found = 1'b1;
                sel_way   = way_t'(i);
            end
        end

        if (!sel_found && !miss_lock[plru_way]) begin
            sel_found = 1'b1;
            sel_way   = plru_way;
        end

        for (int j = 0; j < WAY_NUM; j++) begin
            if (!sel_found && !miss_lock[j]) begin
                sel_found = 1'b1;
                sel_way   = way_t'(j);
            end
        end
    end

    // Same-set updates chain port 0 .. port N-1, then the miss touch; flush wins over all.
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            tree_d[s] = tree_q[s];
            for (int p = 0; p < READ_PORT; p++) begin
                if (hit_en[p] && hit_index[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(s)) begin
                    tree_d[s] = touch(tree_d[s], hit_way[p*WAY_WIDTH +: WAY_WIDTH]);
                end
            end
            if (miss_req && sel_found && miss_index == ADDR_WIDTH'(s)) begin
                tree_d[s] = touch(tree_d[s], sel_way);
            end
            if (flush) begin
                tree_d[s] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the tree state lives in flops, not RAM, because reset must return every set to victim way 0.
            for (int s = 0; s < DEPTH; s++) begin
                tree_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int s = 0; s < DEPTH; s++) begin
                tree_q[s] <= tree_d[s];
            end
        end
    end

    // Responses last exactly one cycle and fall back to zero without a new request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_way_q       <= '0;
            miss_way_valid_q <= 1'b0;
            miss_blocked_q   <= 1'b0;
        end else begin
            miss_way_q       <= miss_req ? sel_way : '0;
            miss_way_valid_q <= miss_req && sel_found;
            miss_blocked_q   <= miss_req && !sel_found;
        end
    end

    assign miss_way       = miss_way_q;
    assign miss_way_valid = miss_way_valid_q;
    assign miss_blocked   = miss_blocked_q;

endmodule

// File: tb/tb_plru_replace_mp.sv
// Directed bench for plru_replace_mp (4 ways, 2 hit ports, 256 sets) with
// hand-computed victim sequences.
module tb_plru_replace_mp;

    localparam int DEPTH      = 256;
    localparam int WAY_NUM    = 4;
    localparam int READ_PORT  = 2;
    localparam int WAY_WIDTH  = 2;
    localparam int ADDR_WIDTH = 8;

    logic                            clk;
    logic                            rst;
    logic                            flush;
    logic [READ_PORT-1:0]            hit_en;
    logic [READ_PORT*ADDR_WIDTH-1:0] hit_index;
    logic [READ_PORT*WAY_WIDTH-1:0]  hit_way;
    logic                            miss_req;
    logic [ADDR_WIDTH-1:0]           miss_index;
    logic [WAY_NUM-1:0]              miss_valid;
    logic [WAY_NUM-1:0]              miss_lock;
    logic [WAY_WIDTH-1:0]            miss_way;
    logic                            miss_way_valid;
    logic                            miss_blocked;

    int checks = 0;
    int errors = 0;

    plru_replace_mp #(
        .DEPTH     (DEPTH),
        .WAY_NUM   (WAY_NUM),
        .READ_PORT (READ_PORT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .hit_en         (hit_en),
        .hit_index      (hit_index),
        .hit_way        (hit_way),
        .miss_req       (miss_req),
        .miss_index     (miss_index),
        .miss_valid     (miss_valid),
        .miss_lock      (miss_lock),
        .miss_way       (miss_way),
        .miss_way_valid (miss_way_valid),
        .miss_blocked   (miss_blocked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_resp(input string tag, input int way, input int vld, input int blk);
        check({tag, ".way"},     32'(miss_way),       32'(way));
        check({tag, ".valid"},   32'(miss_way_valid), 32'(vld));
        check({tag, ".blocked"}, 32'(miss_blocked),   32'(blk));
    endtask

    task automatic set_idle();
        flush      = 1'b0;
        hit_en     = '0;
        hit_index  = '0;
        hit_way    = '0;
        miss_req   = 1'b0;
        miss_index = '0;
        miss_valid = '1;
        miss_lock  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_hit(input int port, input int idx, input int way);
        hit_en[port]                             = 1'b1;
        hit_index[port*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(idx);
        hit_way[port*WAY_WIDTH +: WAY_WIDTH]     = WAY_WIDTH'(way);
    endtask

    task automatic drive_miss(input int idx, input logic [WAY_NUM-1:0] valid, input logic [WAY_NUM-1:0] lock);
        miss_req   = 1'b1;
        miss_index = ADDR_WIDTH'(idx);
        miss_valid = valid;
        miss_lock  = lock;
    endtask

    // One-cycle request with everything valid and unlocked, then check the response.
    task automatic miss_expect(input string tag, input int idx, input int way);
        drive_miss(idx, 4'b1111, 4'b0000);
        tick();
        set_idle();
        check_resp(tag, way, 1, 0);
    endtask

    task automatic hit_cycle(input int idx, input int way);
        drive_hit(0, idx, way);
        tick();
        set_idle();
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        #12;
        check_resp("reset", 0, 0, 0);
        rst = 1'b1;

        // Fresh set returns way 0, then way 2 after touching 0.
        miss_expect("set5_first", 5, 0);
        miss_expect("set5_second", 5, 2);
        tick();
        check_resp("drop_after_resp", 0, 0, 0);

        // Hit 0, 2, 1 on set 3 interleaved with requests.
        hit_cycle(3, 0);
        miss_expect("set3_after_hit0", 3, 2);
        hit_cycle(3, 2);
        miss_expect("set3_after_hit2", 3, 1);
        hit_cycle(3, 1);
        miss_expect("set3_after_hit1", 3, 3);

        // Invalid way wins over the PLRU pointer (which is way 0 on a fresh set).
        drive_miss(10, 4'b1011, 4'b0000);
        tick();
        set_idle();
        check_resp("invalid_pref", 2, 1, 0);

        // Locked PLRU way falls back to the lowest unlocked way.
        drive_miss(20, 4'b1111, 4'b0001);
        tick();
        set_idle();
        check_resp("lock_way0", 1, 1, 0);

        // Fully locked: blocked, and the set state is not touched.
        drive_miss(21, 4'b1111, 4'b1111);
        tick();
        set_idle();
        check_resp("all_locked", 0, 0, 1);
        miss_expect("after_blocked", 21, 0);

        // Two ports on set 7 in one cycle: touch 0 then 2 leaves victim 1.
        drive_hit(0, 7, 0);
        drive_hit(1, 7, 2);
        tick();
        set_idle();
        miss_expect("set7_dual_hit", 7, 1);

        // Set 8: same-cycle request sees pre-update state, then its touch is applied last.
        drive_hit(0, 8, 0);
        drive_hit(1, 8, 2);
        drive_miss(8, 4'b1111, 4'b0000);
        tick();
        set_idle();
        check_resp("set8_same_cycle", 0, 1, 0);
        miss_expect("set8_next", 8, 3);

        // Different sets on the two ports update independently.
        drive_hit(0, 40, 3);
        drive_hit(1, 41, 1);
        tick();
        set_idle();
        miss_expect("set40_indep", 40, 0);
        miss_expect("set41_indep", 41, 2);

        // Flush with a same-cycle hit and a request answered from pre-flush state.
        drive_hit(0, 30, 0);
        drive_hit(1, 31, 0);
        tick();
        set_idle();
        flush = 1'b1;
        drive_hit(0, 30, 1);
        drive_miss(31, 4'b1111, 4'b0000);
        tick();
        set_idle();
        check_resp("flush_cycle_req", 2, 1, 0);
        miss_expect("after_flush_30", 30, 0);
        miss_expect("after_flush_31", 31, 0);
        miss_expect("after_flush_3", 3, 0);
        miss_expect("after_flush_8", 8, 0);

        // Asynchronous reset in the middle of a pending response.
        hit_cycle(50, 0);
        drive_miss(50, 4'b1111, 4'b0000);
        tick();
        set_idle();
        check_resp("pre_async_reset", 2, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        check_resp("async_reset", 0, 0, 0);
        rst = 1'b1;
        miss_expect("after_async_reset", 50, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
